// File: rtl/face_pkg.sv
// rtl/face_pkg.sv - shared face codes and scheduler state encoding
package face_pkg;

  typedef enum logic [1:0] {
    FACE_HAPPY   = 2'd0,
    FACE_NEUTRAL = 2'd1,
    FACE_ANGRY   = 2'd2
  } face_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PEND_AUTO = 2'd1,
    ST_PEND_MAN  = 2'd2,
    ST_SLIDE     = 2'd3
  } sched_state_t;

  localparam logic [1:0] FACE_INVALID = 2'd3;

  // Slideshow order: Happy -> Neutral -> Angry -> Happy
  function automatic logic [1:0] next_face(input logic [1:0] f);
    case (f)
      FACE_HAPPY:   next_face = FACE_NEUTRAL;
      FACE_NEUTRAL: next_face = FACE_ANGRY;
      default:      next_face = FACE_HAPPY;
    endcase
  endfunction

endpackage

// File: rtl/face_req_arbiter.sv
// rtl/face_req_arbiter.sv - manual/auto request priority, readies and accepted face
module face_req_arbiter
  import face_pkg::*;
(
  input  logic [1:0] state,
  input  logic       commit,
  input  logic       man_req_valid,
  input  logic [1:0] man_req_face,
  input  logic       auto_req_valid,
  input  logic [1:0] auto_req_face,
  output logic       man_req_ready,
  output logic       auto_req_ready,
  output logic       acc_valid,
  output logic       acc_is_man,
  output logic [1:0] acc_face
);

  // Manual outranks auto; a commit cycle blocks both so nothing merges into it
  always_comb begin
    man_req_ready  = ((state == ST_IDLE) || (state == ST_PEND_AUTO)) && !commit;
    auto_req_ready = (state == ST_IDLE) && !man_req_valid && !commit;
    acc_is_man     = man_req_valid && man_req_ready;
    acc_valid      = acc_is_man || (auto_req_valid && auto_req_ready);
    acc_face       = acc_is_man ? man_req_face : auto_req_face;
  end

endmodule

// File: rtl/face_scheduler.sv
// rtl/face_scheduler.sv - frame-boundary face select scheduler with dwell and slideshow
module face_scheduler
  import face_pkg::*;
#(
  parameter int MIN_DWELL_FRAMES = 4,
  parameter int SLIDE_FRAMES     = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        man_req_valid,
  input  logic [1:0]  man_req_face,
  output logic        man_req_ready,
  input  logic        auto_req_valid,
  input  logic [1:0]  auto_req_face,
  output logic        auto_req_ready,
  input  logic        slideshow,
  input  logic        st_valid,
  input  logic        st_ready,
  input  logic        st_endofpacket,
  output logic [1:0]  face_select,
  output logic        pending,
  output logic        bad_req,
  output logic [15:0] frame_count
);

  localparam logic [15:0] DWELL_MAX  = 16'(MIN_DWELL_FRAMES);
  localparam logic [15:0] DWELL_THR  = 16'(MIN_DWELL_FRAMES - 1);
  localparam logic [15:0] SLIDE_LAST = 16'(SLIDE_FRAMES - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  face_q, face_d;
  logic [1:0]  latched_q, latched_d;
  logic [15:0] dwell_q, dwell_d;
  logic [15:0] slide_q, slide_d;
  logic [15:0] frame_q, frame_d;
  logic        bad_q, bad_d;

  logic        eop_fire;
  logic        pend;
  logic        commit;
  logic        acc_valid;
  logic        acc_is_man;
  logic [1:0]  acc_face;

  assign eop_fire = st_valid & st_ready & st_endofpacket;
  assign pend     = (state_q == ST_PEND_AUTO) || (state_q == ST_PEND_MAN);
  // A slideshow request in the same cycle outranks the commit
  assign commit   = eop_fire && pend && (dwell_q >= DWELL_THR) && !slideshow;

  face_req_arbiter u_arb (
    .state          (state_q),
    .commit         (commit),
    .man_req_valid  (man_req_valid),
    .man_req_face   (man_req_face),
    .auto_req_valid (auto_req_valid),
    .auto_req_face  (auto_req_face),
    .man_req_ready  (man_req_ready),
    .auto_req_ready (auto_req_ready),
    .acc_valid      (acc_valid),
    .acc_is_man     (acc_is_man),
    .acc_face       (acc_face)
  );

  // Next-state: mode changes first, then slideshow stepping, commit, dwell and acceptance
  always_comb begin
    state_d   = state_q;
    face_d    = face_q;
    latched_d = latched_q;
    dwell_d   = dwell_q;
    slide_d   = slide_q;
    bad_d     = 1'b0;
    frame_d   = eop_fire ? frame_q + 16'd1 : frame_q;

    if (slideshow && (state_q != ST_SLIDE)) begin
      state_d = ST_SLIDE;
      slide_d = 16'd0;
    end else if (!slideshow && (state_q == ST_SLIDE)) begin
      state_d = ST_IDLE;
      dwell_d = 16'd0;
      slide_d = 16'd0;
    end else if (state_q == ST_SLIDE) begin
      if (eop_fire) begin
        if (dwell_q < DWELL_MAX) dwell_d = dwell_q + 16'd1;
        if (slide_q >= SLIDE_LAST) begin
          face_d  = next_face(face_q);
          slide_d = 16'd0;
        end else begin
          slide_d = slide_q + 16'd1;
        end
      end
    end else if (commit) begin
      face_d  = latched_q;
      state_d = ST_IDLE;
      dwell_d = 16'd0;
    end else begin
      if (eop_fire && (dwell_q < DWELL_MAX)) dwell_d = dwell_q + 16'd1;
      if (acc_valid) begin
        if (acc_face == FACE_INVALID) begin
          bad_d = 1'b1;
        end else if ((state_q == ST_IDLE) && (acc_face == face_q)) begin
          state_d = ST_IDLE;
        end else begin
          latched_d = acc_face;
          state_d   = acc_is_man ? ST_PEND_MAN : ST_PEND_AUTO;
        end
      end
    end
  end

  // Register all scheduler state; synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      face_q    <= FACE_HAPPY;
      latched_q <= FACE_HAPPY;
      dwell_q   <= 16'd0;
      slide_q   <= 16'd0;
      frame_q   <= 16'd0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      face_q    <= face_d;
      latched_q <= latched_d;
      dwell_q   <= dwell_d;
      slide_q   <= slide_d;
      frame_q   <= frame_d;
      bad_q     <= bad_d;
    end
  end

  assign face_select = face_q;
  assign pending     = pend;
  assign bad_req     = bad_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_face_scheduler.sv
// tb/tb_face_scheduler.sv - scoreboard bench for face_scheduler
module tb_face_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        man_req_valid, auto_req_valid;
  logic [1:0]  man_req_face, auto_req_face;
  logic        man_req_ready, auto_req_ready;
  logic        slideshow;
  logic        st_valid, st_ready, st_endofpacket;
  logic [1:0]  face_select;
  logic        pending, bad_req;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  face_scheduler #(.MIN_DWELL_FRAMES(4), .SLIDE_FRAMES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .man_req_valid  (man_req_valid),
    .man_req_face   (man_req_face),
    .man_req_ready  (man_req_ready),
    .auto_req_valid (auto_req_valid),
    .auto_req_face  (auto_req_face),
    .auto_req_ready (auto_req_ready),
    .slideshow      (slideshow),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_endofpacket (st_endofpacket),
    .face_select    (face_select),
    .pending        (pending),
    .bad_req        (bad_req),
    .frame_count    (frame_count)
  );

  typedef struct packed {
    logic       is_bad;
    logic [1:0] face;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  frames_sent = 0;
  bit  started = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_face(input logic [1:0] f);
    ev_t e;
    e.is_bad = 1'b0;
    e.face   = f;
    exp_q.push_back(e);
  endtask

  task automatic push_bad();
    ev_t e;
    e.is_bad = 1'b1;
    e.face   = 2'd0;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic r, input logic e);
    st_valid       = v;
    st_ready       = r;
    st_endofpacket = e;
    tick();
  endtask

  // One frame: data beat, two non-firing eop beats, then the firing eop beat
  task automatic frame();
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b1);
    st_valid       = 1'b0;
    st_ready       = 1'b0;
    st_endofpacket = 1'b0;
    frames_sent++;
  endtask

  task automatic accept(input bit is_man, input logic [1:0] f);
    bit ok;
    ok = 1'b0;
    if (is_man) begin
      man_req_valid = 1'b1;
      man_req_face  = f;
    end else begin
      auto_req_valid = 1'b1;
      auto_req_face  = f;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (is_man ? man_req_ready : auto_req_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (is_man) man_req_valid = 1'b0;
    else        auto_req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready 0 expected ready 1 (man=%0d face=%0d)", is_man, f);
    end
  endtask

  // Monitor: every face_select change and bad_req pulse pops one expected event
  logic [1:0] face_prev = 2'd0;
  logic       eop_prev  = 1'b0;
  logic       rst_prev  = 1'b0;
  always @(negedge clk) begin : mon
    ev_t e;
    if (started) begin
      if (face_select !== face_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_face_change: got %0d expected %0d", face_select, face_prev);
        end else begin
          e = exp_q.pop_front();
          if (e.is_bad || (e.face !== face_select) || !(eop_prev || rst_prev)) begin
            errors++;
            $display("FAIL face_event: got face %0d (eop_before=%0d) expected face %0d bad=%0d after eop",
                     face_select, eop_prev, e.face, e.is_bad);
          end
        end
      end
      if (bad_req === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bad_req: got 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_bad) begin
            errors++;
            $display("FAIL bad_event: got bad_req expected face %0d", e.face);
          end
        end
      end
    end
    face_prev = face_select;
    eop_prev  = st_valid & st_ready & st_endofpacket;
    rst_prev  = reset;
  end

  initial begin
    reset          = 1'b1;
    man_req_valid  = 1'b0;
    man_req_face   = 2'd0;
    auto_req_valid = 1'b0;
    auto_req_face  = 2'd0;
    slideshow      = 1'b0;
    st_valid       = 1'b0;
    st_ready       = 1'b0;
    st_endofpacket = 1'b0;
    repeat (3) tick();
    reset   = 1'b0;
    started = 1'b1;
    tick();

    chk("rst_face", {14'd0, face_select}, 16'd0);
    chk("rst_pending", {15'd0, pending}, 16'd0);
    chk("rst_bad", {15'd0, bad_req}, 16'd0);
    chk("rst_man_ready", {15'd0, man_req_ready}, 16'd1);
    chk("rst_auto_ready", {15'd0, auto_req_ready}, 16'd1);
    chk("rst_frame_count", frame_count, 16'd0);

    // Auto 2: holds Happy for 3 frames, commits on the 4th
    push_face(2'd2);
    accept(1'b0, 2'd2);
    chk("t1_pending", {15'd0, pending}, 16'd1);
    chk("t1_auto_ready", {15'd0, auto_req_ready}, 16'd0);
    chk("t1_man_ready", {15'd0, man_req_ready}, 16'd1);
    repeat (3) frame();
    chk("t1_face_3frames", {14'd0, face_select}, 16'd0);
    frame();
    chk("t1_face_4frames", {14'd0, face_select}, 16'd2);
    chk("t1_pending_after", {15'd0, pending}, 16'd0);
    chk("t1_frame_count", frame_count, 16'd4);

    // Both valid: manual 1 wins, auto 2 stalls until after the commit
    auto_req_valid = 1'b1;
    auto_req_face  = 2'd2;
    man_req_valid  = 1'b1;
    man_req_face   = 2'd1;
    #1;
    chk("t2_man_ready", {15'd0, man_req_ready}, 16'd1);
    chk("t2_auto_ready", {15'd0, auto_req_ready}, 16'd0);
    push_face(2'd1);
    accept(1'b1, 2'd1);
    #1;
    chk("t2_auto_stalled", {15'd0, auto_req_ready}, 16'd0);
    chk("t2_pending", {15'd0, pending}, 16'd1);
    repeat (4) frame();
    chk("t2_face_man", {14'd0, face_select}, 16'd1);
    push_face(2'd2);
    accept(1'b0, 2'd2);
    chk("t2_auto_pending", {15'd0, pending}, 16'd1);
    repeat (3) frame();
    chk("t2_face_hold", {14'd0, face_select}, 16'd1);
    frame();
    chk("t2_face_auto", {14'd0, face_select}, 16'd2);

    // Auto 0 pending, replaced by manual 1
    accept(1'b0, 2'd0);
    #1;
    chk("t3_man_ready_pend_auto", {15'd0, man_req_ready}, 16'd1);
    push_face(2'd1);
    accept(1'b1, 2'd1);
    chk("t3_pending", {15'd0, pending}, 16'd1);
    repeat (4) frame();
    chk("t3_face_replaced", {14'd0, face_select}, 16'd1);

    // Face 3 is dropped with a single bad_req pulse; same-face request is dropped silently
    push_bad();
    accept(1'b1, 2'd3);
    chk("t4_bad_high", {15'd0, bad_req}, 16'd1);
    chk("t4_pending", {15'd0, pending}, 16'd0);
    tick();
    chk("t4_bad_low", {15'd0, bad_req}, 16'd0);
    chk("t4_face", {14'd0, face_select}, 16'd1);
    accept(1'b0, 2'd1);
    chk("t4_same_face_pending", {15'd0, pending}, 16'd0);

    // Request arriving in a commit cycle waits one cycle
    push_face(2'd0);
    accept(1'b0, 2'd0);
    repeat (3) frame();
    st_valid       = 1'b1;
    st_ready       = 1'b1;
    st_endofpacket = 1'b1;
    man_req_valid  = 1'b1;
    man_req_face   = 2'd2;
    #1;
    chk("t5_man_ready_commit", {15'd0, man_req_ready}, 16'd0);
    chk("t5_auto_ready_commit", {15'd0, auto_req_ready}, 16'd0);
    @(posedge clk);
    #1;
    st_valid       = 1'b0;
    st_ready       = 1'b0;
    st_endofpacket = 1'b0;
    frames_sent++;
    #1;
    chk("t5_face_commit", {14'd0, face_select}, 16'd0);
    chk("t5_man_ready_after", {15'd0, man_req_ready}, 16'd1);
    push_face(2'd2);
    accept(1'b1, 2'd2);
    chk("t5_pending", {15'd0, pending}, 16'd1);
    repeat (4) frame();
    chk("t5_face_late", {14'd0, face_select}, 16'd2);

    // Slideshow discards a pending request and steps every 2 frames
    accept(1'b0, 2'd1);
    chk("t6_pending_before", {15'd0, pending}, 16'd1);
    slideshow = 1'b1;
    tick();
    chk("t6_pending_slide", {15'd0, pending}, 16'd0);
    chk("t6_man_ready_slide", {15'd0, man_req_ready}, 16'd0);
    chk("t6_auto_ready_slide", {15'd0, auto_req_ready}, 16'd0);
    push_face(2'd0);
    push_face(2'd1);
    push_face(2'd2);
    frame();
    chk("t6_face_1frame", {14'd0, face_select}, 16'd2);
    frame();
    chk("t6_face_2frames", {14'd0, face_select}, 16'd0);
    repeat (4) frame();
    chk("t6_face_6frames", {14'd0, face_select}, 16'd2);
    slideshow = 1'b0;
    tick();
    chk("t6_face_exit", {14'd0, face_select}, 16'd2);
    chk("t6_man_ready_exit", {15'd0, man_req_ready}, 16'd1);
    chk("t6_frame_count", frame_count, 16'(frames_sent));
    slideshow = 1'b1;
    tick();
    frame();

    // Reset mid-slideshow; dwell starts over afterwards
    push_face(2'd0);
    reset     = 1'b1;
    slideshow = 1'b0;
    tick();
    tick();
    reset       = 1'b0;
    frames_sent = 0;
    tick();
    chk("t7_face_reset", {14'd0, face_select}, 16'd0);
    chk("t7_frame_count", frame_count, 16'd0);
    chk("t7_auto_ready", {15'd0, auto_req_ready}, 16'd1);
    push_face(2'd1);
    accept(1'b0, 2'd1);
    repeat (3) frame();
    chk("t7_face_dwell_hold", {14'd0, face_select}, 16'd0);
    frame();
    chk("t7_face_dwell_commit", {14'd0, face_select}, 16'd1);
    chk("t7_frame_count_end", frame_count, 16'(frames_sent));

    tick();
    tick();
    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/face_scheduler.md
# face_scheduler

Controller that owns the `face_select` input of the face streaming source. It arbitrates face-change requests from a manual requester (push-buttons) and an automatic requester (classifier), and commits changes only at frame boundaries. Boundaries are observed on the source's Avalon-ST output. A minimum-dwell rule prevents flicker, and a slideshow mode cycles faces autonomously.

## Interface
Parameters:
- `MIN_DWELL_FRAMES`, default 4: minimum number of complete frames a face is shown before a requested change may commit (≥1).
- `SLIDE_FRAMES`, default 60: number of frames per face in slideshow mode (≥1).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `man_req_valid`  in  1  manual request valid.
- `man_req_face`  in  2  requested face: 0 Happy, 1 Neutral, 2 Angry.
- `man_req_ready`  out  1  manual request accepted when high with valid.
- `auto_req_valid`  in  1  automatic request valid.
- `auto_req_face`  in  2  requested face.
- `auto_req_ready`  out  1  automatic request accepted when high with valid.
- `slideshow`  in  1  level; 1 selects slideshow mode.
- `st_valid`  in  1  monitored stream valid.
- `st_ready`  in  1  monitored stream ready.
- `st_endofpacket`  in  1  monitored stream end-of-frame.
- `face_select`  out  2  registered face select driven to the streaming source.
- `pending`  out  1  a request is latched and awaiting commit.
- `bad_req`  out  1  one-cycle pulse: an accepted request carried face code 3.
- `frame_count`  out  16  completed-frame counter; wraps.

## Operation
- `eop_fire` = `st_valid & st_ready & st_endofpacket`; this is the only frame-boundary event.
- States: IDLE (no pending request), PEND_AUTO (auto request latched), PEND_MAN (manual request latched), SLIDE.
- Request readiness:
  - `man_req_ready` = (IDLE or PEND_AUTO) & !commit.
  - `auto_req_ready` = IDLE & !`man_req_valid` & !commit.
  - In SLIDE both readies are 0.
- Arbitration:
  - Manual wins when both requesters are valid in IDLE.
  - A manual request in PEND_AUTO replaces the latched auto face and moves to PEND_MAN.
- An accepted request with face code 3 is dropped: `bad_req` pulses and the state is unchanged.
- An accepted request equal to the current `face_select` with nothing pending is dropped silently and the state stays IDLE.
- Dwell counter `dwell`:
  - Cleared to 0 on commit.
  - Otherwise incremented on each `eop_fire`, saturating at `MIN_DWELL_FRAMES`.
- Commit:
  - Condition: `eop_fire` & (PEND_AUTO or PEND_MAN) & (`dwell` ≥ `MIN_DWELL_FRAMES`-1).
  - Effect: `face_select` ← latched face, then the state returns to IDLE.
  - When `eop_fire` occurs without meeting the dwell condition, the request stays pending.
- SLIDE:
  - Entered from any state when `slideshow`=1; any pending request is discarded.
  - A slide counter increments on `eop_fire`.
  - When the counter reaches `SLIDE_FRAMES`-1 on an `eop_fire`, `face_select` advances 0→1→2→0 and the counter clears.
  - When `slideshow` falls, go to IDLE. `face_select` holds its value; `dwell` and the slide counter clear.
- `frame_count` increments on every `eop_fire` in all states.

## Timing
- Reset values:
  - `face_select`=0 (Happy); state IDLE.
  - `dwell`, slide counter and `frame_count` = 0.
  - `pending`=0, `bad_req`=0; both readies follow the IDLE rule.
- Reset mid-frame or mid-request discards everything. The first `eop_fire` seen after reset counts toward dwell normally.
- `face_select` changes on the clock edge following the `eop_fire` cycle. The source latches pixel 0 of the next frame on that same handshake, so the first pixel of the next frame already uses the new face. `face_select` never changes outside that edge.
- Request acceptance takes effect on the edge of the handshake cycle; `pending` rises the next cycle. Minimum request-to-commit latency is 1 cycle, requiring `eop_fire` in the cycle right after acceptance with dwell satisfied.
- In a commit cycle both readies are forced to 0, so no request is lost or merged into the commit. This is a combinational path from the `st_*` inputs to the readies.
- A `slideshow` change and `eop_fire` in the same cycle: the mode change wins, and the frame is counted only in `frame_count`.

## Structure
- Shared package `face_pkg`:
  - `face_t` enum (Happy=0, Neutral=1, Angry=2).
  - Scheduler state enum.
  - `FACE_INVALID`=3 constant.
  - `face_t` is imported by the streaming source as well.
- One sub-module, `face_req_arbiter`: combinational priority and ready generation for the two requesters, plus selection of the accepted face. The FSM, dwell counter and slide counter live in the top.

## Test plan
- Reset, then auto request face 2 with `MIN_DWELL_FRAMES`=4 → accepted; `face_select` stays 0 through 3 `eop_fire`s and becomes 2 on the edge after the 4th.
- Both requesters valid in IDLE (manual=1, auto=2) → manual accepted, auto stalled; after the commit, auto is accepted and commits at a later frame once dwell is met.
- Auto 2 pending, then manual 1 → auto face replaced; commit yields `face_select`=1.
- Request face 3 → `bad_req` high exactly 1 cycle; `pending`=0; `face_select` unchanged.
- Request arriving in a commit cycle → ready low that cycle; accepted on the following cycle.
- `slideshow`=1 with `SLIDE_FRAMES`=2 → `face_select` steps 0→1→2→0 every 2 frames; a pending request is discarded; a reset mid-sequence returns `face_select` to 0.
